// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback frame buffer: frame width helper and FSM encoding.
package uart_pkg;

   localparam int BYTE_NUM_DEF = 4;
   localparam int FRAME_W_DEF  = 8 * BYTE_NUM_DEF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2
   } fifo_state_t;

   function automatic int frame_width(input int byte_num);
      return 8 * byte_num;
   endfunction

endpackage

// File: rtl/uart_frame_fifo_ram.sv
// Frame storage for uart_frame_fifo: register array, synchronous write, asynchronous read.
module frame_ram #(
   parameter int W          = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk_50m_i,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [W-1:0]          wr_data,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [W-1:0]          rd_data
);

   // Contents are not reset; the pointers define which entries are meaningful.
   logic [W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk_50m_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_fifo.sv
// Frame FIFO between UART rx and tx: stores CRC-valid frames and launches tx one frame at a time.
// Optional drop counter output drop_cnt_o when UART_FRAME_FIFO_DROP_CNT_EN is defined.
//
// state        | meaning
// ST_IDLE      | waiting for a stored frame
// ST_LAUNCH    | send request raised, waiting for tx busy to rise
// ST_WAIT_DONE | frame in flight, waiting for tx busy to fall
module uart_frame_fifo
   import uart_pkg::*;
#(
   parameter int  BYTE_NUM   = 4,
   parameter int  DEPTH_LOG2 = 2,
   localparam int W          = frame_width(BYTE_NUM),
   localparam int CW         = DEPTH_LOG2 + 1
) (
   input  logic          clk_50m_i,
   input  logic          rst_n_i,
   input  logic          wr_valid_i,
   input  logic          wr_crc_ok_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          tx_busy_i,
   output logic          tx_send_en_o,
   output logic [W-1:0]  tx_data_o,
   output logic [CW-1:0] frame_count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          drop_o
`ifdef UART_FRAME_FIFO_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt_o
`endif
);

   localparam logic [CW-1:0] D_CNT = CW'(2**DEPTH_LOG2);

   fifo_state_t           state, state_nxt;
   logic                  busy_d;
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [W-1:0]          rd_data;
   logic                  push, pop, drop_nxt;
   logic [CW-1:0]         count_nxt;
   logic                  send_en_nxt;
   logic [W-1:0]          data_nxt;

   frame_ram #(
      .W          (W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_frame_ram (
      .clk_50m_i (clk_50m_i),
      .wr_en     (push),
      .wr_addr   (wr_ptr),
      .wr_data   (wr_data_i),
      .rd_addr   (rd_ptr),
      .rd_data   (rd_data)
   );

   // A full buffer still accepts a frame when a slot is freed on the same edge.
   assign push     = wr_valid_i & wr_crc_ok_i & (~full_o | pop);
   assign drop_nxt = wr_valid_i & (~wr_crc_ok_i | (full_o & ~pop));

   always_comb begin
      count_nxt = frame_count_o;
      if (push && !pop) begin
         count_nxt = frame_count_o + CW'(1);
      end else if (pop && !push) begin
         count_nxt = frame_count_o - CW'(1);
      end
   end

   always_comb begin
      state_nxt   = state;
      send_en_nxt = tx_send_en_o;
      data_nxt    = tx_data_o;
      pop         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty_o) begin
               data_nxt    = rd_data;
               send_en_nxt = 1'b1;
               state_nxt   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (tx_busy_i) begin
               send_en_nxt = 1'b0;
               state_nxt   = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (busy_d && !tx_busy_i) begin
               pop       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            send_en_nxt = 1'b0;
            state_nxt   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= ST_IDLE;
         busy_d        <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         frame_count_o <= '0;
         full_o        <= 1'b0;
         empty_o       <= 1'b1;
         drop_o        <= 1'b0;
         tx_send_en_o  <= 1'b0;
         tx_data_o     <= '0;
      end else begin
         state         <= state_nxt;
         busy_d        <= tx_busy_i;
         frame_count_o <= count_nxt;
         full_o        <= (count_nxt == D_CNT);
         empty_o       <= (count_nxt == '0);
         drop_o        <= drop_nxt;
         tx_send_en_o  <= send_en_nxt;
         tx_data_o     <= data_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
      end
   end

`ifdef UART_FRAME_FIFO_DROP_CNT_EN
   always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         drop_cnt_o <= '0;
      end else if (drop_nxt && drop_cnt_o != 16'hFFFF) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_frame_fifo.sv
// Scoreboard bench for uart_frame_fifo with a behavioural transmitter busy model.
module tb_uart_frame_fifo;

   logic        clk_50m_i;
   logic        rst_n_i;
   logic        wr_valid_i;
   logic        wr_crc_ok_i;
   logic [31:0] wr_data_i;
   logic        tx_busy_i;
   logic        tx_send_en_o;
   logic [31:0] tx_data_o;
   logic [2:0]  frame_count_o;
   logic        full_o;
   logic        empty_o;
   logic        drop_o;
`ifdef UART_FRAME_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt_o;
`endif

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];
   int          exp_drops    = 0;
   int          drop_seen    = 0;

   int          busy_delay   = 3;
   int          busy_len     = 100;
   logic        hold_busy    = 1'b0;

   uart_frame_fifo #(.BYTE_NUM(4), .DEPTH_LOG2(2)) dut (
      .clk_50m_i     (clk_50m_i),
      .rst_n_i       (rst_n_i),
      .wr_valid_i    (wr_valid_i),
      .wr_crc_ok_i   (wr_crc_ok_i),
      .wr_data_i     (wr_data_i),
      .tx_busy_i     (tx_busy_i),
      .tx_send_en_o  (tx_send_en_o),
      .tx_data_o     (tx_data_o),
      .frame_count_o (frame_count_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .drop_o        (drop_o)
`ifdef UART_FRAME_FIFO_DROP_CNT_EN
      ,
      .drop_cnt_o    (drop_cnt_o)
`endif
   );

   initial clk_50m_i = 1'b0;
   always #10 clk_50m_i = ~clk_50m_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transmitter model: busy rises busy_delay steps after a request, lasts busy_len steps (or while held).
   initial begin
      int phase;
      int cnt;
      phase     = 0;
      cnt       = 0;
      tx_busy_i = 1'b0;
      forever begin
         @(posedge clk_50m_i);
         #2;
         if (!rst_n_i) begin
            phase     = 0;
            tx_busy_i = 1'b0;
         end else begin
            case (phase)
               0: if (tx_send_en_o && !tx_busy_i) begin
                     cnt   = busy_delay;
                     phase = 1;
                  end
               1: begin
                     cnt--;
                     if (cnt <= 0) begin
                        tx_busy_i = 1'b1;
                        cnt       = busy_len;
                        phase     = 2;
                     end
                  end
               default: begin
                     if (cnt > 1) cnt--;
                     else if (!hold_busy) begin
                        tx_busy_i = 1'b0;
                        phase     = 0;
                     end
                  end
            endcase
         end
      end
   end

   // Monitor: every new launch pops the scoreboard; data must hold while the request is up.
   initial begin
      logic        prev_en;
      logic [31:0] last;
      logic [31:0] exp;
      prev_en = 1'b0;
      last    = '0;
      forever begin
         @(negedge clk_50m_i);
         if (tx_send_en_o && !prev_en) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL tx_frame: got unexpected launch %h, expected no launch", tx_data_o);
            end else begin
               exp = exp_q.pop_front();
               check("tx_frame", tx_data_o, exp);
            end
            last = tx_data_o;
         end else if (tx_send_en_o) begin
            check("tx_hold", tx_data_o, last);
         end
         if (drop_o) drop_seen++;
         prev_en = tx_send_en_o;
      end
   end

   task automatic push(input logic [31:0] data, input logic crc, input logic accept);
      @(negedge clk_50m_i);
      wr_valid_i  = 1'b1;
      wr_crc_ok_i = crc;
      wr_data_i   = data;
      if (accept) exp_q.push_back(data);
      else exp_drops++;
      @(negedge clk_50m_i);
      wr_valid_i  = 1'b0;
      wr_crc_ok_i = 1'b0;
   endtask

   task automatic wait_busy(input logic lvl, input int budget);
      int n = 0;
      while (tx_busy_i !== lvl && n < budget) begin
         @(negedge clk_50m_i);
         n++;
      end
      if (tx_busy_i !== lvl) begin
         tests_run++;
         tests_failed++;
         $display("FAIL wait_busy: timeout with busy=%b, expected %b", tx_busy_i, lvl);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (!(empty_o && !tx_send_en_o && !tx_busy_i) && n < budget) begin
         @(negedge clk_50m_i);
         n++;
      end
      check("drain_empty", {31'd0, empty_o}, 32'd1);
      check("drain_scoreboard", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_send_en"}, {31'd0, tx_send_en_o}, 32'd0);
      check({tag, "_tx_data"}, tx_data_o, 32'd0);
      check({tag, "_count"}, {29'd0, frame_count_o}, 32'd0);
      check({tag, "_full"}, {31'd0, full_o}, 32'd0);
      check({tag, "_empty"}, {31'd0, empty_o}, 32'd1);
      check({tag, "_drop"}, {31'd0, drop_o}, 32'd0);
   endtask

   initial begin
      rst_n_i     = 1'b0;
      wr_valid_i  = 1'b0;
      wr_crc_ok_i = 1'b0;
      wr_data_i   = '0;
      repeat (3) @(negedge clk_50m_i);
      rst_n_i = 1'b1;
      @(negedge clk_50m_i);
      check_reset_values("reset");

      // Single frame, full timing walk-through.
      busy_delay = 3;
      busy_len   = 100;
      push(32'hA5A5_1234, 1'b1, 1'b1);
      check("t1_count_after_push", {29'd0, frame_count_o}, 32'd1);
      check("t1_empty_after_push", {31'd0, empty_o}, 32'd0);
      check("t1_send_en_early", {31'd0, tx_send_en_o}, 32'd0);
      @(negedge clk_50m_i);
      check("t1_send_en_rise", {31'd0, tx_send_en_o}, 32'd1);
      wait_busy(1'b1, 20);
      check("t1_send_en_before_launch_edge", {31'd0, tx_send_en_o}, 32'd1);
      @(negedge clk_50m_i);
      check("t1_send_en_cleared", {31'd0, tx_send_en_o}, 32'd0);
      check("t1_data_wait_done", tx_data_o, 32'hA5A5_1234);
      wait_busy(1'b0, 200);
      check("t1_count_before_pop", {29'd0, frame_count_o}, 32'd1);
      @(negedge clk_50m_i);
      check("t1_count_after_pop", {29'd0, frame_count_o}, 32'd0);
      check("t1_empty_after_pop", {31'd0, empty_o}, 32'd1);
      repeat (3) @(negedge clk_50m_i);
      check("t1_no_relaunch", {31'd0, tx_send_en_o}, 32'd0);

      // Overflow: five frames while the transmitter is stuck busy.
      busy_len  = 5;
      hold_busy = 1'b1;
      for (int i = 1; i <= 4; i++) push(32'(i), 1'b1, 1'b1);
      check("t2_full_before_5th", {31'd0, full_o}, 32'd1);
      push(32'd5, 1'b1, 1'b0);
      check("t2_drop_on_5th", {31'd0, drop_o}, 32'd1);
      check("t2_count_sat", {29'd0, frame_count_o}, 32'd4);
      check("t2_full", {31'd0, full_o}, 32'd1);
      @(negedge clk_50m_i);
      check("t2_drop_one_cycle", {31'd0, drop_o}, 32'd0);
      hold_busy = 1'b0;
      wait_drain(400);

      // Bad CRC frame.
      push(32'h0BAD_0BAD, 1'b0, 1'b0);
      check("t3_drop", {31'd0, drop_o}, 32'd1);
      check("t3_count", {29'd0, frame_count_o}, 32'd0);
      repeat (3) @(negedge clk_50m_i);
      check("t3_send_en", {31'd0, tx_send_en_o}, 32'd0);
      check("t3_empty", {31'd0, empty_o}, 32'd1);

      // Full buffer with push and pop on the same edge.
      hold_busy = 1'b1;
      for (int i = 10; i <= 13; i++) push(32'(i), 1'b1, 1'b1);
      repeat (10) @(negedge clk_50m_i);
      check("t4_count_full", {29'd0, frame_count_o}, 32'd4);
      hold_busy = 1'b0;
      push(32'd14, 1'b1, 1'b1);
      check("t4_no_drop", {31'd0, drop_o}, 32'd0);
      check("t4_count_stays", {29'd0, frame_count_o}, 32'd4);
      check("t4_full_stays", {31'd0, full_o}, 32'd1);
      wait_drain(400);

      // Reset while a frame is in flight with another stored.
      hold_busy = 1'b1;
      push(32'd20, 1'b1, 1'b1);
      push(32'd21, 1'b1, 1'b1);
      repeat (8) @(negedge clk_50m_i);
      check("t5_count_before_rst", {29'd0, frame_count_o}, 32'd2);
      check("t5_wait_done_send_en", {31'd0, tx_send_en_o}, 32'd0);
      rst_n_i = 1'b0;
      #1;
      check_reset_values("t5_async_rst");
      exp_q.delete();
      hold_busy = 1'b0;
      @(negedge clk_50m_i);
      @(negedge clk_50m_i);
      rst_n_i = 1'b1;
      @(negedge clk_50m_i);
      push(32'hDEAD_BEEF, 1'b1, 1'b1);
      wait_drain(400);

      // Three bad frames after reset.
      for (int i = 0; i < 3; i++) push(32'hF00 + 32'(i), 1'b0, 1'b0);
      @(negedge clk_50m_i);
`ifdef UART_FRAME_FIFO_DROP_CNT_EN
      check("t6_drop_cnt", {16'd0, drop_cnt_o}, 32'd3);
`endif
      check("t6_count", {29'd0, frame_count_o}, 32'd0);

      repeat (3) @(negedge clk_50m_i);
      check("drop_total", drop_seen, exp_drops);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1);
   end

endmodule

// File: doc/uart_frame_fifo.md
Name: uart_frame_fifo

Overview:
- Frame buffer between the n-byte UART receiver and the n-byte UART transmitter in the loopback path.
- Stores whole CRC-valid frames of BYTE_NUM bytes in a circular buffer.
- Launches the transmitter one frame at a time, using the transmitter busy level as the completion handshake.
- Replaces the top-level rx/tx counter comparison, so back-to-back received frames are no longer lost or overwritten.

Parameters:
- BYTE_NUM, 4, bytes per frame; frame width W = 8*BYTE_NUM.
- DEPTH_LOG2, 2, log2 of the frame capacity; depth D = 2**DEPTH_LOG2 (default 4 frames).

Ports:
- clk_50m_i  in  1  system clock, 50 MHz.
- rst_n_i  in  1  asynchronous active-low reset.
- wr_valid_i  in  1  one-cycle pulse: receiver finished a frame.
- wr_crc_ok_i  in  1  parity/CRC result for the frame, qualified by wr_valid_i.
- wr_data_i  in  W  received frame, qualified by wr_valid_i.
- tx_busy_i  in  1  transmitter busy level.
- tx_send_en_o  out  1  transmitter launch request (level).
- tx_data_o  out  W  frame presented to the transmitter.
- frame_count_o  out  DEPTH_LOG2+1  number of stored frames.
- full_o  out  1  frame_count_o == D.
- empty_o  out  1  frame_count_o == 0.
- drop_o  out  1  one-cycle pulse: incoming frame discarded.

Interface: reset rst_n_i, asynchronous, active-low; clock clk_50m_i. All outputs are registered.

Behaviour:
- Reset values:
  - tx_send_en_o = 0, tx_data_o = 0, frame_count_o = 0, full_o = 0, empty_o = 1, drop_o = 0.
  - Read and write pointers = 0; FSM = IDLE; busy_d = 0.
  - Storage contents are don't-care.
- Push is attempted on any edge with wr_valid_i = 1.
  - If wr_crc_ok_i = 0: frame discarded, drop_o = 1 next cycle, no state change.
  - If wr_crc_ok_i = 1 and (!full, or a pop happens on the same edge): write mem[wr_ptr]; wr_ptr wraps modulo D.
  - If wr_crc_ok_i = 1, full, and no pop on the same edge: frame discarded, drop_o = 1.
- Pop condition: FSM in WAIT_DONE and busy falling edge detected. busy_d is tx_busy_i registered one cycle; the falling edge is busy_d = 1 and tx_busy_i = 0.
  - On pop, rd_ptr increments and wraps modulo D.
- Count: +1 on push only, -1 on pop only, unchanged when push and pop occur together. full_o and empty_o are updated on the same edge as the count.
- FSM states:
  - IDLE: if !empty, load tx_data_o <= mem[rd_ptr], set tx_send_en_o = 1, go to LAUNCH.
  - LAUNCH: hold tx_send_en_o = 1 and tx_data_o. When tx_busy_i = 1, clear tx_send_en_o and go to WAIT_DONE.
  - WAIT_DONE: hold tx_data_o. On busy falling edge, pop and return to IDLE.
- Latency:
  - With the FIFO empty, a push sampled on edge N gives tx_send_en_o = 1 after edge N+1.
  - After a pop on edge P, the next frame's tx_send_en_o = 1 after edge P+1 (one idle cycle minimum).
- tx_busy_i = 1 while in IDLE is ignored. Busy pulses shorter than one cycle are not supported.
- No timeout: LAUNCH is held until busy rises.
- Reset asserted mid-frame aborts immediately; the stored frame is lost (the transmitter shares the same reset).

Optional Feature:
- Macro: UART_FRAME_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o, 16 bits, reset 0.
  - Increments on every drop_o pulse and saturates at 16'hFFFF.
- Undefined: the port and the counter do not exist; drop_o is unchanged either way.

Decomposition:
- Shared package uart_pkg: localparams for frame width (8*BYTE_NUM) and the FSM state encoding (IDLE, LAUNCH, WAIT_DONE, 2 bits).
- One sub-module, frame_ram: a D x W register array with synchronous write and asynchronous read, instantiated once. Pointer and count logic stay in the parent.

Test Plan:
- One frame 32'hA5A5_1234 with crc_ok = 1; the busy model goes high 3 cycles after the request and stays high 100 cycles -> send_en rises 2 edges after the push, drops on the first busy cycle, tx_data_o = 32'hA5A5_1234 throughout, count goes 1 -> 0 one edge after busy falls.
- Push 5 good frames (values 1..5) while busy is held high -> count saturates at 4, full_o = 1, drop_o pulses once on the 5th push; frames 1..4 are transmitted in order, and frame 5 is never transmitted.
- Push with crc_ok = 0 -> drop_o pulses, count stays 0, send_en stays 0.
- Full FIFO with push and pop on the same edge -> push accepted, count stays 4, no drop; the new frame is transmitted after the other three.
- Assert rst_n_i during WAIT_DONE with count 2 -> all outputs return to reset values immediately; post-reset push of 32'hDEAD_BEEF is transmitted normally.
- With UART_FRAME_FIFO_DROP_CNT_EN defined: 3 bad-CRC pushes -> drop_cnt_o = 3.
